gcd_arbiter: RTL and testbench
==============================

Name: gcd_arbiter

Overview:
- Shares one GCD engine between NUM_REQ independent requesters.
- Round-robin arbitration selects one requester; its operand pair is latched and issued to the engine over the engine's req/busy/valid handshake.
- The engine result is returned on a single shared response channel tagged with the requester index.
- Sits between client blocks and the GCD engine, replacing per-client operand-load logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, operand/result width.
- ID_W, $clog2(NUM_REQ), response tag width (derived, not overridable).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a_i  in  NUM_REQ*DATA_W  operand A, requester k at bits [k*DATA_W +: DATA_W].
- req_b_i  in  NUM_REQ*DATA_W  operand B, same packing.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accept.
- rsp_id_o  out  ID_W  index of the requester being answered.
- rsp_result_o  out  DATA_W  GCD result.
- rsp_err_o  out  1  request rejected: zero operand, or timeout when enabled.
- eng_req_o  out  1  engine request.
- eng_a_o  out  DATA_W  engine operand A.
- eng_b_o  out  DATA_W  engine operand B.
- eng_busy_i  in  1  engine busy.
- eng_valid_i  in  1  engine result valid, single-cycle pulse.
- eng_result_i  in  DATA_W  engine result.

Behaviour:
- Reset values: FSM=IDLE, rr pointer=0, all outputs 0.
- Reset mid-operation aborts the transaction with no response; the engine is expected to be reset alongside.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESPOND.
- IDLE:
  - If any req_valid_i is set, grant the first set bit at or after the rr pointer, wrapping.
  - Pulse req_ready_o[grant] for exactly one cycle; the transfer occurs that cycle.
  - Latch A, B and grant id into internal registers.
  - If A==0 or B==0: go to RESPOND with result=0 and err=1; the engine is not used.
  - Otherwise go to ISSUE.
- ISSUE:
  - eng_req_o=1; eng_a_o/eng_b_o driven from the latches and held stable.
  - When eng_busy_i=1 in a cycle, drop eng_req_o next cycle and go to WAIT_DONE.
- WAIT_DONE:
  - eng_req_o=0; operands held.
  - On eng_valid_i=1, capture eng_result_i and go to RESPOND.
  - eng_valid_i outside WAIT_DONE is ignored.
- RESPOND:
  - rsp_valid_o=1; rsp_id_o, rsp_result_o and rsp_err_o are stable until the cycle where rsp_ready_i=1.
  - On that cycle: go to IDLE and set rr pointer = (id+1) mod NUM_REQ.
- Latency, nonzero operands: accept at cycle 0, eng_req_o at cycle 1, response 1 cycle after eng_valid_i.
- Latency, zero operand: response at cycle 1.
- No new request is accepted until the response completes; a back-to-back grant is possible in the IDLE cycle immediately following.
- Lower index wins only when it is at or after the rr pointer; a requester holding req_valid_i waits at most NUM_REQ-1 transactions.
- req_valid_i dropping before grant: no state effect.

Optional Feature:
- Macro: GCD_ARB_TIMEOUT_EN.
- When defined: an 8-bit counter runs in ISSUE and WAIT_DONE and is cleared on entry to ISSUE. At count 255 the FSM goes to RESPOND with result=0 and err=1, and eng_req_o drops.
- When undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Package gcd_pkg: state enum type gcd_arb_state_e, TIMEOUT_MAX constant (255), default DATA_W.
- One sub-module, rr_arbiter: combinational round-robin priority select taking valid vector and pointer, returning a one-hot grant and an index. It is reusable elsewhere.

Test Plan:
- Single request: req0 A=12, B=8; engine model returns 4 after 5 cycles -> rsp_id=0, result=4, err=0; eng_a_o=12 and eng_b_o=8 stable throughout ISSUE/WAIT_DONE.
- Zero operand: req2 A=0, B=7 -> response at cycle 1 with id=2, result=0, err=1; eng_req_o never asserts.
- Fairness: req0..req3 held valid continuously -> grants in order 0,1,2,3,0,1; no requester is skipped.
- Response backpressure: rsp_ready_i low for 10 cycles -> rsp outputs stable, no req_ready_o pulses, next grant the cycle after acceptance.
- Reset mid-WAIT_DONE: assert rst_i -> all outputs 0 asynchronously; after release a fresh request (9,6) returns 3 with id as granted.
- Timeout, macro defined: engine never pulses eng_valid_i -> response with err=1 and result=0 exactly 256 cycles after ISSUE entry.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine arbiter.
// GCD_ARB_TIMEOUT_EN enables the engine watchdog.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESPOND
    } gcd_arb_state_e;

    localparam int TIMEOUT_W      = 8;
    localparam int TIMEOUT_MAX    = 255;
    localparam int DEFAULT_DATA_W = 4;

endpackage

// File: rtl/gcd_arbiter_rr.sv
// Combinational round-robin select: first valid bit at or
// after the pointer, wrapping, as one-hot grant plus index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int   k;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr_i) + i) % N;
            if (!found && valid_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one GCD engine among NUM_REQ requesters, round-robin.
// Define GCD_ARB_TIMEOUT_EN to abort stalled engine jobs.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = DEFAULT_DATA_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]         rsp_result_o,
    output logic                      rsp_err_o,
    output logic                      eng_req_o,
    output logic [DATA_W-1:0]         eng_a_o,
    output logic [DATA_W-1:0]         eng_b_o,
    input  logic                      eng_busy_i,
    input  logic                      eng_valid_i,
    input  logic [DATA_W-1:0]         eng_result_i
);

    gcd_arb_state_e    state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              err_q, err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gidx;
    logic               gany;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;

`ifdef GCD_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
`endif

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr (
        .valid_i (req_valid_i),
        .ptr_i   (rr_q),
        .gnt_o   (gnt),
        .idx_o   (gidx),
        .any_o   (gany)
    );

    assign sel_a = req_a_i[gidx*DATA_W +: DATA_W];
    assign sel_b = req_b_i[gidx*DATA_W +: DATA_W];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
`ifdef GCD_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
`ifdef GCD_ARB_TIMEOUT_EN
        cnt_d   = cnt_q + 1'b1;
`endif
        unique case (state_q)
            IDLE: begin
                if (gany) begin
                    a_d   = sel_a;
                    b_d   = sel_b;
                    id_d  = gidx;
                    res_d = '0;
                    // Zero operands never reach the engine.
                    if (sel_a == '0 || sel_b == '0) begin
                        err_d   = 1'b1;
                        state_d = RESPOND;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ISSUE;
                    end
                end
`ifdef GCD_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            ISSUE: begin
                if (eng_busy_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (eng_valid_i) begin
                    res_d   = eng_result_i;
                    err_d   = 1'b0;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                    rr_d = (id_q == ID_W'(NUM_REQ - 1))
                         ? '0 : id_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef GCD_ARB_TIMEOUT_EN
        // A result arriving on the last tick still wins.
        if ((state_q == ISSUE || state_q == WAIT_DONE)
            && cnt_q == TIMEOUT_W'(TIMEOUT_MAX)
            && !(state_q == WAIT_DONE && eng_valid_i)) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = RESPOND;
        end
`endif
    end

    always_comb begin
        req_ready_o  = '0;
        if (state_q == IDLE && !rst_i) req_ready_o = gnt;
        eng_req_o    = (state_q == ISSUE);
        eng_a_o      = a_q;
        eng_b_o      = b_q;
        rsp_valid_o  = (state_q == RESPOND);
        rsp_id_o     = id_q;
        rsp_result_o = res_q;
        rsp_err_o    = err_q;
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter with a behavioural engine.
// Timeout scenario runs when GCD_ARB_TIMEOUT_EN is defined.
module tb_gcd_arbiter;

    localparam int NR = 4;
    localparam int DW = 4;
    localparam int IW = 2;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [NR-1:0]    req_valid_i;
    logic [NR-1:0]    req_ready_o;
    logic [NR*DW-1:0] req_a_i;
    logic [NR*DW-1:0] req_b_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [IW-1:0]    rsp_id_o;
    logic [DW-1:0]    rsp_result_o;
    logic             rsp_err_o;
    logic             eng_req_o;
    logic [DW-1:0]    eng_a_o;
    logic [DW-1:0]    eng_b_o;
    logic             eng_busy_i;
    logic             eng_valid_i;
    logic [DW-1:0]    eng_result_i;

    gcd_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .rsp_err_o    (rsp_err_o),
        .eng_req_o    (eng_req_o),
        .eng_a_o      (eng_a_o),
        .eng_b_o      (eng_b_o),
        .eng_busy_i   (eng_busy_i),
        .eng_valid_i  (eng_valid_i),
        .eng_result_i (eng_result_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] res;
        logic          err;
    } exp_t;

    exp_t sbq[$];
    int   grants[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   eng_lat = 3;
    logic exp_timeout = 1'b0;
    logic eng_req_seen = 1'b0;

    function automatic logic [DW-1:0] gcd(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        logic [DW-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Engine model: busy after a request, result after eng_lat cycles.
    initial begin
        int ecnt;
        logic [DW-1:0] ea, eb;
        eng_busy_i = 1'b0;
        eng_valid_i = 1'b0;
        eng_result_i = '0;
        ecnt = 0;
        ea = '0;
        eb = '0;
        forever begin
            @(posedge clk_i);
            #2;
            if (rst_i) begin
                eng_busy_i = 1'b0;
                eng_valid_i = 1'b0;
                ecnt = 0;
            end else begin
                eng_valid_i = 1'b0;
                if (eng_busy_i) begin
                    ecnt--;
                    if (ecnt <= 0) begin
                        eng_busy_i = 1'b0;
                        eng_valid_i = 1'b1;
                        eng_result_i = gcd(ea, eb);
                    end
                end else if (eng_req_o) begin
                    eng_busy_i = 1'b1;
                    ecnt = eng_lat;
                    ea = eng_a_o;
                    eb = eng_b_o;
                end
            end
        end
    end

    // Push on transfer, pop and compare on response handshake.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (eng_req_o) eng_req_seen = 1'b1;
            if (!$onehot0(req_ready_o)) begin
                vectors++;
                miscompares++;
                $display("FAIL ready_onehot got=%b", req_ready_o);
            end
            for (int k = 0; k < NR; k++) begin
                if (req_ready_o[k] && req_valid_i[k]) begin
                    exp_t e;
                    logic [DW-1:0] a, b;
                    a = req_a_i[k*DW +: DW];
                    b = req_b_i[k*DW +: DW];
                    e.id  = IW'(k);
                    e.err = (a == 0 || b == 0 || exp_timeout);
                    e.res = e.err ? '0 : gcd(a, b);
                    sbq.push_back(e);
                    grants.push_back(k);
                end
            end
            if (rsp_valid_o && rsp_ready_i) begin
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected id=%0d", rsp_id_o);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (rsp_id_o !== e.id || rsp_result_o !== e.res
                        || rsp_err_o !== e.err) begin
                        miscompares++;
                        $display("FAIL sb_rsp got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                                 rsp_id_o, rsp_result_o, rsp_err_o,
                                 e.id, e.res, e.err);
                    end
                end
            end
        end
    end

    task automatic do_req(input int k, input logic [DW-1:0] a,
                          input logic [DW-1:0] b);
        bit got;
        @(posedge clk_i);
        #1;
        req_a_i[k*DW +: DW] = a;
        req_b_i[k*DW +: DW] = b;
        req_valid_i[k] = 1'b1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk_i);
            if (req_ready_o[k]) got = 1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_timeout req=%0d", k);
        end
        @(posedge clk_i);
        #1;
        req_valid_i[k] = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk_i);
            #3;
            if (sbq.size() == 0 && !rsp_valid_o) done = 1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout pending=%0d", sbq.size());
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        vectors++;
        if (req_ready_o !== '0 || rsp_valid_o !== 1'b0
            || eng_req_o !== 1'b0 || rsp_err_o !== 1'b0
            || rsp_id_o !== '0 || rsp_result_o !== '0
            || eng_a_o !== '0 || eng_b_o !== '0) begin
            miscompares++;
            $display("FAIL %s rdy=%b rv=%b er=%b id=%0d res=%0d a=%0d b=%0d",
                     tag, req_ready_o, rsp_valid_o, eng_req_o,
                     rsp_id_o, rsp_result_o, eng_a_o, eng_b_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_zero_outputs("reset_state");
        sbq.delete();
        grants.delete();
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        bit ev_prev, seen;
        eng_lat = 5;
        do_req(0, 4'd12, 4'd8);
        @(negedge clk_i);
        vectors++;
        if (eng_req_o !== 1'b1) begin
            miscompares++;
            $display("FAIL single_eng_req got=%b exp=1", eng_req_o);
        end
        ev_prev = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (rsp_valid_o) begin
                seen = 1;
                vectors++;
                if (!ev_prev || rsp_result_o !== 4'd4
                    || rsp_id_o !== 2'd0 || rsp_err_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_rsp ev=%b res=%0d id=%0d err=%b",
                             ev_prev, rsp_result_o, rsp_id_o, rsp_err_o);
                end
            end else begin
                vectors++;
                if (eng_a_o !== 4'd12 || eng_b_o !== 4'd8) begin
                    miscompares++;
                    $display("FAIL single_operands a=%0d b=%0d exp=12/8",
                             eng_a_o, eng_b_o);
                end
                ev_prev = eng_valid_i;
                @(negedge clk_i);
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL single_rsp_timeout");
        end
        wait_idle();
        eng_lat = 3;
    endtask

    task automatic test_zero_operand();
        eng_req_seen = 1'b0;
        do_req(2, 4'd0, 4'd7);
        @(negedge clk_i);
        vectors++;
        if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd2
            || rsp_result_o !== '0 || rsp_err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_rsp v=%b id=%0d res=%0d err=%b exp=1/2/0/1",
                     rsp_valid_o, rsp_id_o, rsp_result_o, rsp_err_o);
        end
        wait_idle();
        vectors++;
        if (eng_req_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_eng_req got=1 exp=0");
        end
    endtask

    task automatic test_fairness();
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        bit done;
        test_reset();
        @(posedge clk_i);
        #1;
        req_a_i = {4'd10, 4'd15, 4'd9, 4'd12};
        req_b_i = {4'd4, 4'd5, 4'd6, 4'd8};
        req_valid_i = 4'hF;
        done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(posedge clk_i);
            #3;
            if (grants.size() >= 6) done = 1;
        end
        req_valid_i = '0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL fair_timeout grants=%0d", grants.size());
        end
        wait_idle();
        for (int i = 0; i < 6 && i < grants.size(); i++) begin
            vectors++;
            if (grants[i] != exp_order[i]) begin
                miscompares++;
                $display("FAIL fair_order[%0d] got=%0d exp=%0d",
                         i, grants[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        do_req(1, 4'd9, 4'd6);
        req_a_i[3*DW +: DW] = 4'd10;
        req_b_i[3*DW +: DW] = 4'd4;
        req_valid_i[3] = 1'b1;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) seen = 1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL bp_rsp_timeout");
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd1
                || rsp_result_o !== 4'd3 || rsp_err_o !== 1'b0
                || req_ready_o !== '0) begin
                miscompares++;
                $display("FAIL bp_hold v=%b id=%0d res=%0d rdy=%b",
                         rsp_valid_o, rsp_id_o, rsp_result_o, req_ready_o);
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        vectors++;
        if (req_ready_o !== 4'b1000) begin
            miscompares++;
            $display("FAIL bp_next_grant got=%b exp=1000", req_ready_o);
        end
        @(posedge clk_i);
        #1;
        req_valid_i[3] = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        bit seen;
        eng_lat = 1000;
        do_req(0, 4'd5, 4'd10);
        repeat (4) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check_zero_outputs("reset_mid_async");
        sbq.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        eng_lat = 3;
        do_req(2, 4'd9, 4'd6);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) seen = 1;
        end
        vectors++;
        if (!seen || rsp_id_o !== 2'd2 || rsp_result_o !== 4'd3
            || rsp_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_rsp seen=%b id=%0d res=%0d exp=2/3",
                     seen, rsp_id_o, rsp_result_o);
        end
        wait_idle();
    endtask

`ifdef GCD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        bit seen;
        eng_lat = 1000;
        exp_timeout = 1'b1;
        do_req(1, 4'd6, 4'd4);
        cyc = 0;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) seen = 1;
            else cyc++;
        end
        vectors++;
        if (!seen || cyc != 256 || rsp_err_o !== 1'b1
            || rsp_result_o !== '0 || eng_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout seen=%b cyc=%0d exp=256 err=%b res=%0d",
                     seen, cyc, rsp_err_o, rsp_result_o);
        end
        wait_idle();
        exp_timeout = 1'b0;
        eng_lat = 3;
        test_reset();
    endtask
`endif

    initial begin
        rst_i = 1'b1;
        req_valid_i = '0;
        req_a_i = '0;
        req_b_i = '0;
        rsp_ready_i = 1'b1;
        test_reset();
        test_single();
        test_zero_operand();
        test_fairness();
        test_backpressure();
        test_reset_mid();
`ifdef GCD_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
